// File: rtl/rx_fifo_ctrl.sv
// Receive FIFO sequencer for one DUART channel.
// Arbitrates rx writes vs CPU reads, flushes, tracks error status.
module rx_fifo_ctrl #(
    parameter int PTR_W  = 2,
    parameter int STAT_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_char_valid,
    input  logic [7:0]        rx_char,
    input  logic [STAT_W-1:0] rx_stat,
    input  logic              cpu_rhr_rd,
    input  logic              cmd_rx_en,
    input  logic              cmd_rx_dis,
    input  logic              cmd_rx_reset,
    input  logic              cmd_err_reset,
    input  logic              mr1_rxint_sel,
    input  logic              mr1_err_mode,
    input  logic              fifo_rxrdy,
    input  logic              fifo_ffull,
    output logic              fifo_rd,
    output logic              fifo_wr,
    output logic [7:0]        fifo_din,
    output logic              sr_rxrdy,
    output logic              sr_ffull,
    output logic              sr_overrun,
    output logic [STAT_W-1:0] sr_err,
    output logic              rx_irq,
    output logic              rx_enabled
);

    localparam int DEPTH = 2**PTR_W;

    typedef enum logic [1:0] {
        DISABLED,
        ENABLED,
        FLUSH_RD,
        FLUSH_GAP
    } state_t;

    state_t            state;
    logic              rd_prev;
    logic              pend_valid;
    logic [7:0]        pend_char;
    logic [STAT_W-1:0] pend_stat;
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [STAT_W-1:0] mirror [DEPTH];
    logic [STAT_W-1:0] blk_err;

    logic              flushing;
    logic              cpu_rd;
    logic              flush_rd;
    logic              accept;
    logic              want_wr;
    logic              ovr_set;
    logic              err_clr;
    logic [STAT_W-1:0] wr_stat;

    assign flushing = (state == FLUSH_RD) || (state == FLUSH_GAP);

    // A level CPU read becomes one pulse on its rising edge
    assign cpu_rd   = cpu_rhr_rd && !rd_prev && fifo_rxrdy && !flushing;
    assign flush_rd = (state == FLUSH_RD) && fifo_rxrdy;
    assign fifo_rd  = cpu_rd || flush_rd;

    // New chars only enter in ENABLED and never on the reset command
    assign accept  = rx_char_valid && (state == ENABLED) && !cmd_rx_reset;

    // Pending goes first; a fresh char writes through if pending is free
    assign want_wr  = (pend_valid || accept) && !fifo_rd;
    assign fifo_wr  = want_wr && !fifo_ffull;
    assign fifo_din = pend_valid ? pend_char : rx_char;
    assign wr_stat  = pend_valid ? pend_stat : rx_stat;

    // Full FIFO at write time, or a char arriving on a busy pending slot
    assign ovr_set = (want_wr && fifo_ffull) || (accept && pend_valid);
    assign err_clr = cmd_err_reset || cmd_rx_reset;

    assign sr_rxrdy   = fifo_rxrdy && !flushing;
    assign sr_ffull   = fifo_ffull && !flushing;
    assign rx_enabled = (state == ENABLED);

    // Error field: head-of-FIFO status or accumulated block status
    always_comb begin
        sr_err = '0;
        if (mr1_err_mode) begin
            sr_err = blk_err;
        end else if (fifo_rxrdy && !flushing) begin
            sr_err = mirror[rptr];
        end
    end

    // Receiver state machine and read-pointer realignment after flush
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FLUSH_RD;
            rptr  <= '0;
        end else begin
            if (fifo_rd) begin
                rptr <= rptr + PTR_W'(1);
            end
            unique case (state)
                DISABLED: begin
                    if (cmd_rx_reset) begin
                        state <= FLUSH_RD;
                    end else if (cmd_rx_en) begin
                        state <= ENABLED;
                    end
                end
                ENABLED: begin
                    if (cmd_rx_reset) begin
                        state <= FLUSH_RD;
                    end else if (cmd_rx_dis) begin
                        state <= DISABLED;
                    end
                end
                FLUSH_RD: begin
                    if (fifo_rxrdy) begin
                        state <= FLUSH_GAP;
                    end else begin
                        state <= DISABLED;
                        rptr  <= wptr;
                    end
                end
                FLUSH_GAP: begin
                    state <= FLUSH_RD;
                end
                default: state <= FLUSH_RD;
            endcase
        end
    end

    // Pending slot holds a char that slipped behind a FIFO read
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_char  <= '0;
            pend_stat  <= '0;
            rd_prev    <= 1'b0;
        end else begin
            rd_prev <= cpu_rhr_rd;
            if (cmd_rx_reset) begin
                pend_valid <= 1'b0;
            end else if (pend_valid) begin
                if (!fifo_rd) begin
                    pend_valid <= 1'b0;
                end
            end else if (accept && fifo_rd) begin
                pend_valid <= 1'b1;
                pend_char  <= rx_char;
                pend_stat  <= rx_stat;
            end
        end
    end

    // Status mirror written in lockstep with the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
        end else if (fifo_wr) begin
            mirror[wptr] <= wr_stat;
            wptr         <= wptr + PTR_W'(1);
        end
    end

    // Sticky overrun and block-mode error accumulation; set beats clear
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_overrun <= 1'b0;
            blk_err    <= '0;
        end else begin
            if (ovr_set) begin
                sr_overrun <= 1'b1;
            end else if (err_clr) begin
                sr_overrun <= 1'b0;
            end
            if (fifo_wr) begin
                blk_err <= (err_clr ? '0 : blk_err) | wr_stat;
            end else if (err_clr) begin
                blk_err <= '0;
            end
        end
    end

    // Registered interrupt, masked while flushing
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_irq <= 1'b0;
        end else begin
            rx_irq <= !flushing &&
                      (mr1_rxint_sel ? fifo_ffull : fifo_rxrdy);
        end
    end

endmodule

// File: tb/tb_rx_fifo_ctrl.sv
// Directed bench for rx_fifo_ctrl with a 3-deep FIFO model.
module tb_rx_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_char_valid = 1'b0;
    logic [7:0] rx_char = 8'h00;
    logic [2:0] rx_stat = 3'b000;
    logic       cpu_rhr_rd = 1'b0;
    logic       cmd_rx_en = 1'b0;
    logic       cmd_rx_dis = 1'b0;
    logic       cmd_rx_reset = 1'b0;
    logic       cmd_err_reset = 1'b0;
    logic       mr1_rxint_sel = 1'b0;
    logic       mr1_err_mode = 1'b0;
    logic       fifo_rxrdy = 1'b0;
    logic       fifo_ffull = 1'b0;
    logic       fifo_rd;
    logic       fifo_wr;
    logic [7:0] fifo_din;
    logic       sr_rxrdy;
    logic       sr_ffull;
    logic       sr_overrun;
    logic [2:0] sr_err;
    logic       rx_irq;
    logic       rx_enabled;

    int checks = 0;
    int errors = 0;
    int collide = 0;
    logic [7:0] q [$];
    logic [7:0] popped = 8'h00;
    logic       wr_seen;
    logic [7:0] din_seen;

    rx_fifo_ctrl #(.PTR_W(2), .STAT_W(3)) dut (
        .clk(clk), .rst(rst),
        .rx_char_valid(rx_char_valid), .rx_char(rx_char),
        .rx_stat(rx_stat), .cpu_rhr_rd(cpu_rhr_rd),
        .cmd_rx_en(cmd_rx_en), .cmd_rx_dis(cmd_rx_dis),
        .cmd_rx_reset(cmd_rx_reset), .cmd_err_reset(cmd_err_reset),
        .mr1_rxint_sel(mr1_rxint_sel), .mr1_err_mode(mr1_err_mode),
        .fifo_rxrdy(fifo_rxrdy), .fifo_ffull(fifo_ffull),
        .fifo_rd(fifo_rd), .fifo_wr(fifo_wr), .fifo_din(fifo_din),
        .sr_rxrdy(sr_rxrdy), .sr_ffull(sr_ffull),
        .sr_overrun(sr_overrun), .sr_err(sr_err),
        .rx_irq(rx_irq), .rx_enabled(rx_enabled)
    );

    always #5 clk = ~clk;

    // Behavioural 3-deep FIFO; flags update after the edge
    always @(posedge clk) begin
        if (fifo_rd && fifo_wr) collide++;
        if (fifo_rd && q.size() > 0) popped = q.pop_front();
        if (fifo_wr && q.size() < 3) q.push_back(fifo_din);
        fifo_rxrdy <= (q.size() != 0);
        fifo_ffull <= (q.size() == 3);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c, input logic [2:0] s);
        rx_char_valid = 1'b1;
        rx_char = c;
        rx_stat = s;
        @(negedge clk);
        wr_seen = fifo_wr;
        din_seen = fifo_din;
        tick();
        rx_char_valid = 1'b0;
    endtask

    task automatic rd_once();
        cpu_rhr_rd = 1'b1;
        tick();
        cpu_rhr_rd = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({fifo_rd, fifo_wr, sr_rxrdy, sr_ffull, sr_overrun,
             sr_err, rx_irq, rx_enabled} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0",
                {fifo_rd, fifo_wr, sr_rxrdy, sr_ffull, sr_overrun,
                 sr_err, rx_irq, rx_enabled});
        end
        tick();
    endtask

    task automatic test_overrun();
        logic [7:0] exp [3];
        exp[0] = 8'h41;
        exp[1] = 8'h42;
        exp[2] = 8'h43;
        cmd_rx_en = 1'b1;
        tick();
        cmd_rx_en = 1'b0;
        checks++;
        if (rx_enabled !== 1'b1) begin
            errors++;
            $display("FAIL enable got %b want 1", rx_enabled);
        end
        for (int i = 0; i < 3; i++) begin
            send(exp[i], 3'b000);
            checks++;
            if (wr_seen !== 1'b1 || din_seen !== exp[i]) begin
                errors++;
                $display("FAIL fill_wr got %b/%h want 1/%h",
                    wr_seen, din_seen, exp[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (sr_ffull !== 1'b1) begin
            errors++;
            $display("FAIL ffull got %b want 1", sr_ffull);
        end
        tick();
        send(8'h44, 3'b000);
        checks++;
        if (wr_seen !== 1'b0 || sr_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun got wr=%b ovr=%b want 0/1",
                wr_seen, sr_overrun);
        end
        for (int i = 0; i < 3; i++) begin
            rd_once();
            checks++;
            if (popped !== exp[i]) begin
                errors++;
                $display("FAIL read_data got %h want %h", popped, exp[i]);
            end
        end
        checks++;
        if (sr_overrun !== 1'b1 || sr_rxrdy !== 1'b0) begin
            errors++;
            $display("FAIL ovr_sticky got ovr=%b rdy=%b want 1/0",
                sr_overrun, sr_rxrdy);
        end
        cmd_err_reset = 1'b1;
        tick();
        cmd_err_reset = 1'b0;
        checks++;
        if (sr_overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear got %b want 0", sr_overrun);
        end
    endtask

    task automatic test_collision();
        send(8'h50, 3'b000);
        tick();
        rx_char_valid = 1'b1;
        rx_char = 8'h51;
        cpu_rhr_rd = 1'b1;
        @(negedge clk);
        checks++;
        if (fifo_rd !== 1'b1 || fifo_wr !== 1'b0) begin
            errors++;
            $display("FAIL coll_same got rd=%b wr=%b want 1/0",
                fifo_rd, fifo_wr);
        end
        tick();
        rx_char_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (fifo_rd !== 1'b0 || fifo_wr !== 1'b1 || fifo_din !== 8'h51) begin
            errors++;
            $display("FAIL coll_slip got rd=%b wr=%b din=%h want 0/1/51",
                fifo_rd, fifo_wr, fifo_din);
        end
        tick();
        cpu_rhr_rd = 1'b0;
        checks++;
        if (popped !== 8'h50) begin
            errors++;
            $display("FAIL coll_first got %h want 50", popped);
        end
        tick();
        rd_once();
        checks++;
        if (popped !== 8'h51 || sr_rxrdy !== 1'b0) begin
            errors++;
            $display("FAIL coll_second got %h rdy=%b want 51/0",
                popped, sr_rxrdy);
        end
    endtask

    task automatic test_level_read();
        int pulses = 0;
        send(8'h60, 3'b000);
        send(8'h61, 3'b000);
        tick();
        cpu_rhr_rd = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fifo_rd === 1'b1) pulses++;
            tick();
        end
        cpu_rhr_rd = 1'b0;
        checks++;
        if (pulses != 1 || popped !== 8'h60) begin
            errors++;
            $display("FAIL level_hold got %0d pulses data %h want 1/60",
                pulses, popped);
        end
        tick();
        rd_once();
        checks++;
        if (popped !== 8'h61 || sr_rxrdy !== 1'b0) begin
            errors++;
            $display("FAIL level_reraise got %h rdy=%b want 61/0",
                popped, sr_rxrdy);
        end
    endtask

    task automatic test_flush();
        logic [5:0] rds;
        logic [5:0] exp_rds;
        exp_rds = 6'b000101;
        send(8'h70, 3'b010);
        send(8'h71, 3'b001);
        tick();
        cmd_rx_reset = 1'b1;
        tick();
        cmd_rx_reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rds[i] = fifo_rd;
            tick();
        end
        checks++;
        if (rds !== exp_rds) begin
            errors++;
            $display("FAIL flush_rd got %b want %b", rds, exp_rds);
        end
        @(negedge clk);
        checks++;
        if (rx_enabled !== 1'b0 || sr_rxrdy !== 1'b0 || sr_err !== 3'b000
            || q.size() != 0) begin
            errors++;
            $display("FAIL flush_end got en=%b rdy=%b err=%b n=%0d want 0",
                rx_enabled, sr_rxrdy, sr_err, q.size());
        end
        tick();
        send(8'h7f, 3'b000);
        checks++;
        if (wr_seen !== 1'b0) begin
            errors++;
            $display("FAIL disabled_drop got wr=%b want 0", wr_seen);
        end
        cmd_rx_en = 1'b1;
        tick();
        cmd_rx_en = 1'b0;
    endtask

    task automatic test_err_modes();
        logic [2:0] exp_char [4];
        exp_char[0] = 3'b010;
        exp_char[1] = 3'b000;
        exp_char[2] = 3'b001;
        exp_char[3] = 3'b000;
        mr1_err_mode = 1'b1;
        send(8'h80, 3'b001);
        send(8'h81, 3'b000);
        send(8'h82, 3'b100);
        rd_once();
        rd_once();
        rd_once();
        checks++;
        if (sr_err !== 3'b101 || sr_rxrdy !== 1'b0) begin
            errors++;
            $display("FAIL block_err got %b want 101", sr_err);
        end
        cmd_err_reset = 1'b1;
        tick();
        cmd_err_reset = 1'b0;
        checks++;
        if (sr_err !== 3'b000) begin
            errors++;
            $display("FAIL block_clear got %b want 000", sr_err);
        end
        mr1_err_mode = 1'b0;
        send(8'h90, 3'b010);
        send(8'h91, 3'b000);
        send(8'h92, 3'b001);
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sr_err !== exp_char[i]) begin
                errors++;
                $display("FAIL char_err[%0d] got %b want %b",
                    i, sr_err, exp_char[i]);
            end
            if (i < 3) rd_once();
        end
    endtask

    task automatic test_irq();
        mr1_rxint_sel = 1'b1;
        send(8'ha0, 3'b000);
        send(8'ha1, 3'b000);
        tick();
        tick();
        checks++;
        if (rx_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_ffull_two got %b want 0", rx_irq);
        end
        send(8'ha2, 3'b000);
        checks++;
        if (sr_ffull !== 1'b1 || rx_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_ffull_lat got ff=%b irq=%b want 1/0",
                sr_ffull, rx_irq);
        end
        tick();
        checks++;
        if (rx_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_ffull got %b want 1", rx_irq);
        end
        rd_once();
        rd_once();
        rd_once();
        mr1_rxint_sel = 1'b0;
        tick();
        checks++;
        if (rx_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_empty got %b want 0", rx_irq);
        end
        send(8'hb0, 3'b000);
        checks++;
        if (sr_rxrdy !== 1'b1 || rx_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_rdy_lat got rdy=%b irq=%b want 1/0",
                sr_rxrdy, rx_irq);
        end
        tick();
        checks++;
        if (rx_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_rxrdy got %b want 1", rx_irq);
        end
        rd_once();
    endtask

    initial begin
        test_reset();
        test_overrun();
        test_collision();
        test_level_read();
        test_flush();
        test_err_modes();
        test_irq();
        checks++;
        if (collide != 0) begin
            errors++;
            $display("FAIL rd_wr_overlap got %0d want 0", collide);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
